// File: rtl/player_input_checker.sv
// player_input_checker: debounces four active-low buttons and checks each press against an 18-bit tile sequence.
// Define PLAYER_TIMEOUT_EN to build a per-press timeout that fails the round.
module player_input_checker #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned TIMEOUT_CYCLES  = 250000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [17:0] seq,
  input  logic [3:0]  length,
  input  logic [3:0]  key_n,
  output logic        busy,
  output logic        press_valid,
  output logic [1:0]  press_tile,
  output logic [3:0]  index,
  output logic        pass,
  output logic        fail
);

  localparam int unsigned DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned MAX_LEN = 9;

  if (DEBOUNCE_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("player_input_checker: DEBOUNCE_CYCLES and TIMEOUT_CYCLES must be nonzero");
  end

  typedef enum logic [2:0] {
    S_IDLE, S_ARM, S_WAIT, S_DEBOUNCE, S_COMPARE, S_TIMEOUT
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       key_s1, key_s2, key;
  logic [DEB_W-1:0] deb_cnt, deb_nxt;
  logic [3:0]       cap, cap_nxt;
  logic [17:0]      seq_q, seq_nxt;
  logic [3:0]       len_q, len_nxt, len_clamped;
  logic [3:0]       index_nxt;
  logic [1:0]       tile_nxt, cap_tile, exp_tile;
  logic             busy_nxt, pv_nxt, pass_nxt, fail_nxt;
  logic             key_one_hot, deb_done, last_pos;

`ifdef PLAYER_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
`endif

  assign key         = ~key_s2;
  assign key_one_hot = (key != 4'd0) && ((key & (key - 4'd1)) == 4'd0);
  assign deb_done    = (deb_cnt == DEB_W'(DEBOUNCE_CYCLES - 1));
  assign len_clamped = (length > 4'(MAX_LEN)) ? 4'(MAX_LEN) : length;
  assign last_pos    = (index == len_q - 4'd1);

  // Tile expected at the current position of the latched sequence
  always_comb begin
    case (index)
      4'd0:    exp_tile = seq_q[1:0];
      4'd1:    exp_tile = seq_q[3:2];
      4'd2:    exp_tile = seq_q[5:4];
      4'd3:    exp_tile = seq_q[7:6];
      4'd4:    exp_tile = seq_q[9:8];
      4'd5:    exp_tile = seq_q[11:10];
      4'd6:    exp_tile = seq_q[13:12];
      4'd7:    exp_tile = seq_q[15:14];
      4'd8:    exp_tile = seq_q[17:16];
      default: exp_tile = 2'd0;
    endcase
  end

  always_comb begin
    case (cap)
      4'b0010: cap_tile = 2'd1;
      4'b0100: cap_tile = 2'd2;
      4'b1000: cap_tile = 2'd3;
      default: cap_tile = 2'd0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    deb_nxt   = deb_cnt;
    cap_nxt   = cap;
    seq_nxt   = seq_q;
    len_nxt   = len_q;
    index_nxt = index;
    tile_nxt  = press_tile;
    pv_nxt    = 1'b0;
    pass_nxt  = 1'b0;
    fail_nxt  = 1'b0;
`ifdef PLAYER_TIMEOUT_EN
    tmo_nxt   = tmo_cnt;
`endif
    case (state)
      // A start coincident with a verdict pulse is dropped
      S_IDLE: begin
        if (start && !pass && !fail) begin
          seq_nxt = seq;
          len_nxt = len_clamped;
          if (len_clamped == 4'd0) begin
            pass_nxt = 1'b1;
          end else begin
            index_nxt = 4'd0;
            deb_nxt   = '0;
            state_nxt = S_ARM;
`ifdef PLAYER_TIMEOUT_EN
            tmo_nxt   = '0;
`endif
          end
        end
      end
      S_ARM: begin
        if (key != 4'd0) begin
          deb_nxt = '0;
        end else if (deb_done) begin
          deb_nxt   = '0;
          state_nxt = S_WAIT;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (key_one_hot) begin
          cap_nxt   = key;
          deb_nxt   = '0;
          state_nxt = S_DEBOUNCE;
        end
      end
      S_DEBOUNCE: begin
        if (key != cap) begin
          deb_nxt   = '0;
          state_nxt = S_WAIT;
        end else if (deb_done) begin
          deb_nxt   = '0;
          state_nxt = S_COMPARE;
          pv_nxt    = 1'b1;
          tile_nxt  = cap_tile;
          if (cap_tile != exp_tile) fail_nxt = 1'b1;
          else if (last_pos)        pass_nxt = 1'b1;
        end else begin
          deb_nxt = deb_cnt + 1'b1;
        end
      end
      // Verdict registers already hold the comparison result
      S_COMPARE: begin
        if (pass || fail) begin
          state_nxt = S_IDLE;
        end else begin
          index_nxt = index + 4'd1;
          state_nxt = S_ARM;
        end
      end
      S_TIMEOUT: state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
`ifdef PLAYER_TIMEOUT_EN
    // Timeout overrides whatever the waiting states decided
    if (state == S_COMPARE) begin
      tmo_nxt = '0;
    end else if (state == S_ARM || state == S_WAIT || state == S_DEBOUNCE) begin
      if (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) begin
        state_nxt = S_TIMEOUT;
        deb_nxt   = '0;
        tile_nxt  = press_tile;
        pv_nxt    = 1'b0;
        pass_nxt  = 1'b0;
        fail_nxt  = 1'b1;
      end else begin
        tmo_nxt = tmo_cnt + 1'b1;
      end
    end
`endif
    busy_nxt = (state_nxt != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      key_s1      <= 4'hF;
      key_s2      <= 4'hF;
      deb_cnt     <= '0;
      cap         <= '0;
      seq_q       <= '0;
      len_q       <= '0;
      index       <= '0;
      press_tile  <= '0;
      busy        <= 1'b0;
      press_valid <= 1'b0;
      pass        <= 1'b0;
      fail        <= 1'b0;
`ifdef PLAYER_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      state       <= state_nxt;
      key_s1      <= key_n;
      key_s2      <= key_s1;
      deb_cnt     <= deb_nxt;
      cap         <= cap_nxt;
      seq_q       <= seq_nxt;
      len_q       <= len_nxt;
      index       <= index_nxt;
      press_tile  <= tile_nxt;
      busy        <= busy_nxt;
      press_valid <= pv_nxt;
      pass        <= pass_nxt;
      fail        <= fail_nxt;
`ifdef PLAYER_TIMEOUT_EN
      tmo_cnt     <= tmo_nxt;
`endif
    end
  end

endmodule

// File: doc/player_input_checker.md
# player_input_checker

Responder side of the tile-sequence game. The display path plays an 18-bit tile sequence to the player; this block reads the player's four push-buttons and compares each debounced press against the same sequence in order. It reports each accepted press and then a single pass or fail verdict per round to the game controller.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 500000: cycles a key level must hold stable before it is accepted (10 ms at 50 MHz).
- `TIMEOUT_CYCLES`, default 250000000: per-press time limit (5 s). Used only with `PLAYER_TIMEOUT_EN`.

Ports:
- `clock`  in  1  system clock (CLOCK_50 domain).
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle pulse that begins a checking round. Ignored while `busy`.
- `seq`  in  18  tile sequence; tile i is `seq[2i+1:2i]`, and i=0 is played first.
- `length`  in  4  number of tiles to check. Values 10-15 are clamped to 9.
- `key_n`  in  4  raw asynchronous buttons, active-low; `key_n[k]` means tile k.
- `busy`  out  1  high from the cycle after an accepted `start` until the verdict.
- `press_valid`  out  1  one-cycle pulse per accepted press.
- `press_tile`  out  2  tile of the accepted press. Valid with `press_valid`, held otherwise.
- `index`  out  4  position currently expected (0-based).
- `pass`  out  1  one-cycle pulse when all `length` tiles match.
- `fail`  out  1  one-cycle pulse on mismatch (or timeout).

## Operation
- `key_n` goes through a 2-flop synchronizer, then is inverted to `key`.
- `seq` and the clamped `length` are latched on an accepted `start`. Later changes to these inputs are ignored for the rest of the round.
- States:
  - IDLE: `busy`=0. On `start`:
    - length 0 → `pass` pulse the next cycle, stay in IDLE.
    - otherwise → `index`=0 and go to ARM.
  - ARM: wait until `key`==0 for DEBOUNCE_CYCLES consecutive cycles, then go to WAIT. Any key clears the counter.
  - WAIT: exactly one key high → capture it and go to DEBOUNCE with count 0. Zero or several keys high → stay.
  - DEBOUNCE: count while `key` equals the one-hot captured value.
    - Any change → WAIT, count cleared.
    - Count reaches DEBOUNCE_CYCLES-1 → go to COMPARE.
  - COMPARE (1 cycle): `press_valid`=1, `press_tile`=captured tile.
    - Tile equals `seq[2*index+1:2*index]` and index < length-1 → `index`+1, go to ARM.
    - Tile matches and index == length-1 → `pass`=1, go to IDLE.
    - Mismatch → `fail`=1, go to IDLE. `index` holds the failing position.
- `pass` and `fail` are never high in the same cycle.
- `busy` falls in the cycle after the verdict pulse.
- Reset at any time: state IDLE and all counters cleared. Any in-flight round is abandoned with no verdict.

## Timing
- Reset values: `busy`=0, `press_valid`=0, `press_tile`=0, `index`=0, `pass`=0, `fail`=0.
- `start` at edge t → `busy`=1 at t+1.
- In WAIT, `key_n[k]` falls before edge t and is held:
  - the synchronized key is seen at t+2;
  - DEBOUNCE is entered at t+3;
  - `press_valid` is high in cycle t+3+DEBOUNCE_CYCLES.
- The verdict pulse is coincident with the final `press_valid`.
- A `start` arriving in the same cycle as a verdict pulse is ignored.
- All outputs are registered.

## Configuration
- `PLAYER_TIMEOUT_EN` defined: a timeout counter runs in ARM, WAIT and DEBOUNCE.
  - It is cleared on an accepted `start` and on every COMPARE.
  - When it reaches TIMEOUT_CYCLES-1: `fail`=1 with no `press_valid`, then go to IDLE.
- `PLAYER_TIMEOUT_EN` undefined: no counter logic is built, and the player may wait indefinitely.

## Test plan
Benches use DEBOUNCE_CYCLES=4 and TIMEOUT_CYCLES=64.
- Correct round: seq=18'h0_1E4 (tiles 0,1,2,3,1), length=5, keys pressed and released in that order → five `press_valid` pulses with tiles 0,1,2,3,1. `pass` coincides with the 5th pulse; `fail` is never asserted.
- Mismatch: same seq, press 0 then 3 → one good `press_valid`, then `press_valid` with tile 3 together with `fail`, `index`=1, `busy`=0 one cycle later.
- Bounce and chord handling:
  - `key_n[2]` toggled low for 2 cycles → no press.
  - Keys 1 and 2 held together → no press.
  - Key 1 held alone for ≥8 cycles → exactly one press of tile 1, with no repeat until it is released.
- Boundaries:
  - length=0 → `pass` at t+1 and `busy` stays 0.
  - length=12 → behaves as 9 presses.
  - `start` while `busy` → no effect on `index` or the latched `seq`.
- Reset mid-round: assert `reset` during DEBOUNCE → all outputs 0 next cycle, no verdict. A fresh `start` then runs normally.
- With `PLAYER_TIMEOUT_EN`: `start`, then no keys for 64 cycles → `fail` without `press_valid`. Without the macro → no `fail` after 1000 idle cycles.
